// File: rtl/mod_count_sampler.sv
// Samples an asynchronous ripple mod-N counter into clk_i, filters ripple glitches,
// and turns count changes into accumulated totals and handshaked increment deltas.
module mod_count_sampler #(
    parameter int N             = 3,
    parameter int STABLE_CYCLES = 2,
    parameter int CLEAR_CYCLES  = 2,
    parameter int ACC_W         = 16,
    localparam int CW           = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CW-1:0]    count_i,
    output logic             clear_o,
    input  logic             clear_req_i,
    output logic             busy_o,
    output logic [ACC_W-1:0] total_o,
    output logic             overflow_o,
    output logic             delta_valid_o,
    output logic [ACC_W-1:0] delta_o,
    input  logic             delta_ready_i
);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CW:0] NW = (CW + 1)'(N);

    typedef enum logic [1:0] {CLEAR, SETTLE, IDLE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    sync1_q, sync2_q;
    logic [CW-1:0]    cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CW-1:0]    base_q, base_d;
    logic [CLR_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;
    logic             dv_q, dv_d;
    logic [ACC_W-1:0] delta_q, delta_d;

    logic             stable;
    logic [CW:0]      diff_raw, diff_mod;
    logic [CW-1:0]    d;
    logic             has_d;
    logic [ACC_W-1:0] d_ext;
    logic [ACC_W:0]   tsum, dsum;

    always_comb begin
        // Run length counts edges on which s matched the previous sample, saturating.
        if (sync2_q == cand_q)
            run_d = (run_q == RUN_W'(STABLE_CYCLES)) ? run_q : run_q + 1'b1;
        else
            run_d = RUN_W'(1);
        cand_d = sync2_q;
        stable = (run_d == RUN_W'(STABLE_CYCLES));

        // Modular difference kept non-negative by adding N before subtracting.
        diff_raw = {1'b0, sync2_q} + NW - {1'b0, base_q};
        diff_mod = (diff_raw >= NW) ? diff_raw - NW : diff_raw;
        d        = diff_mod[CW-1:0];
        has_d    = stable && (d != '0);
        d_ext    = ACC_W'(d);
        tsum     = {1'b0, total_q} + {1'b0, d_ext};
        dsum     = {1'b0, delta_q} + {1'b0, d_ext};

        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        dv_d    = dv_q;
        delta_d = delta_q;

        case (state_q)
            CLEAR: begin
                if (cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (stable && sync2_q == '0) begin
                    state_d = IDLE;
                    base_d  = '0;
                    total_d = '0;
                    ovf_d   = 1'b0;
                    dv_d    = 1'b0;
                    delta_d = '0;
                    run_d   = '0;
                    cand_d  = '0;
                end
            end
            IDLE: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (has_d) begin
                        total_d = tsum[ACC_W-1:0];
                        ovf_d   = ovf_q | tsum[ACC_W];
                        base_d  = sync2_q;
                    end
                    if (dv_q && delta_ready_i) begin
                        dv_d    = has_d;
                        delta_d = has_d ? d_ext : '0;
                    end else if (has_d) begin
                        dv_d    = 1'b1;
                        delta_d = dsum[ACC_W] ? '1 : dsum[ACC_W-1:0];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            run_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            total_q <= '0;
            ovf_q   <= 1'b0;
            dv_q    <= 1'b0;
            delta_q <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= count_i;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            run_q   <= run_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
            dv_q    <= dv_d;
            delta_q <= delta_d;
        end
    end

    // The upstream clear is held for exactly the non-IDLE states, same as busy.
    assign clear_o       = busy_q;
    assign busy_o        = busy_q;
    assign total_o       = total_q;
    assign overflow_o    = ovf_q;
    assign delta_valid_o = dv_q;
    assign delta_o       = delta_q;
endmodule

// File: tb/tb_mod_count_sampler.sv
// Randomized and directed bench for mod_count_sampler; a wide-total instance and a
// 3-bit-total instance share stimulus and are checked against an integer model.
module tb_mod_count_sampler;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  count;
    logic        clear_req;
    logic        ready;
    logic        clr_a, busy_a, ovf_a, dv_a;
    logic [15:0] total_a, delta_a;
    logic        clr_b, busy_b, ovf_b, dv_b;
    logic [2:0]  total_b, delta_b;

    mod_count_sampler #(.N(N), .STABLE_CYCLES(2), .CLEAR_CYCLES(2), .ACC_W(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .count_i(count), .clear_o(clr_a), .clear_req_i(clear_req),
        .busy_o(busy_a), .total_o(total_a), .overflow_o(ovf_a), .delta_valid_o(dv_a),
        .delta_o(delta_a), .delta_ready_i(ready));

    mod_count_sampler #(.N(N), .STABLE_CYCLES(2), .CLEAR_CYCLES(2), .ACC_W(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .count_i(count), .clear_o(clr_b), .clear_req_i(clear_req),
        .busy_o(busy_b), .total_o(total_b), .overflow_o(ovf_b), .delta_valid_o(dv_b),
        .delta_o(delta_b), .delta_ready_i(ready));

    always #5 clk = ~clk;

    int p_cnt = 0;
    int t_cnt = 0;
    // Model: current upstream value, advances since last clear, advances not yet handed off.
    int cur = 0;
    int adv = 0;
    int pend = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input int nv, input int hold);
        int d;
        d = (nv + N - cur) % N;
        cur = nv;
        count = 2'(nv);
        adv += d;
        pend = ready ? 0 : pend + d;
        repeat (hold) step();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_a !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) n = -1;
    endtask

    task automatic test_reset();
        #12;
        t_cnt++; if (clr_a !== 1'b1) $display("FAIL reset_clear got=%b exp=1", clr_a); else p_cnt++;
        t_cnt++; if (busy_b !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy_b); else p_cnt++;
        t_cnt++; if ({total_a, delta_a, dv_a, ovf_a} !== 34'd0)
            $display("FAIL reset_outs got=%h/%h/%b/%b exp=0", total_a, delta_a, dv_a, ovf_a); else p_cnt++;
    endtask

    task automatic test_boot();
        int n;
        int nclr;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nclr = 0;
        n = 0;
        while (busy_a !== 1'b0 && n < 40) begin
            if (clr_a === 1'b1) nclr++;
            step();
            n++;
        end
        t_cnt++; if (n >= 40 || nclr < 2) $display("FAIL boot_clear_len got=%0d exp>=2 (n=%0d)", nclr, n); else p_cnt++;
        t_cnt++; if (clr_a !== 1'b0) $display("FAIL boot_clear_drop got=%b exp=0", clr_a); else p_cnt++;
        t_cnt++; if (total_a !== 16'd0 || dv_a !== 1'b0)
            $display("FAIL boot_outs got=%0d/%b exp=0/0", total_a, dv_a); else p_cnt++;
        adv = 0; pend = 0; cur = 0;
        repeat (4) step();
    endtask

    task automatic test_single_step();
        ready = 1'b1;
        move(1, 3);
        t_cnt++; if (dv_a !== 1'b0) $display("FAIL step_early_valid got=%b exp=0", dv_a); else p_cnt++;
        step();
        t_cnt++; if (dv_a !== 1'b1 || delta_a !== 16'd1)
            $display("FAIL step_edge4 got=%b/%0d exp=1/1", dv_a, delta_a); else p_cnt++;
        t_cnt++; if (total_a !== 16'(adv)) $display("FAIL step_total got=%0d exp=%0d", total_a, adv); else p_cnt++;
        step();
        t_cnt++; if (dv_a !== 1'b0) $display("FAIL step_xfer got=%b exp=0", dv_a); else p_cnt++;
        repeat (2) step();
    endtask

    task automatic test_wrap();
        move(2, 6);
        t_cnt++; if (total_a !== 16'd2) $display("FAIL wrap_t2 got=%0d exp=2", total_a); else p_cnt++;
        move(0, 6);
        t_cnt++; if (total_a !== 16'd3) $display("FAIL wrap_t3 got=%0d exp=3", total_a); else p_cnt++;
        move(2, 4);
        t_cnt++; if (dv_a !== 1'b1 || delta_a !== 16'd2)
            $display("FAIL wrap_jump got=%b/%0d exp=1/2", dv_a, delta_a); else p_cnt++;
        repeat (2) step();
        t_cnt++; if (total_a !== 16'd5) $display("FAIL wrap_t5 got=%0d exp=5", total_a); else p_cnt++;
    endtask

    task automatic test_glitch();
        count = 2'd3;
        step();
        count = 2'(cur);
        repeat (6) step();
        t_cnt++; if (total_a !== 16'(adv) || dv_a !== 1'b0)
            $display("FAIL glitch got=%0d/%b exp=%0d/0", total_a, dv_a, adv); else p_cnt++;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            move((cur + 1) % N, 6);
            t_cnt++; if (dv_a !== 1'b1 || delta_a !== 16'(k))
                $display("FAIL bp_merge%0d got=%b/%0d exp=1/%0d", k, dv_a, delta_a, k); else p_cnt++;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            t_cnt++; if (dv_a !== 1'b1 || delta_a !== 16'd3)
                $display("FAIL bp_hold got=%b/%0d exp=1/3", dv_a, delta_a); else p_cnt++;
        end
        ready = 1'b1;
        step();
        pend = 0;
        t_cnt++; if (dv_a !== 1'b0 || delta_a !== 16'd0)
            $display("FAIL bp_release got=%b/%0d exp=0/0", dv_a, delta_a); else p_cnt++;
        t_cnt++; if (total_a !== 16'(adv)) $display("FAIL bp_total got=%0d exp=%0d", total_a, adv); else p_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        ready = 1'b0;
        move((cur + 1) % N, 6);
        #2;
        rst_n = 1'b0;
        #1;
        t_cnt++; if (clr_a !== 1'b1 || busy_a !== 1'b1 || dv_a !== 1'b0 || delta_a !== 16'd0 || total_a !== 16'd0)
            $display("FAIL rst_mid got=%b%b%b/%0d/%0d exp=110/0/0", clr_a, busy_a, dv_a, delta_a, total_a); else p_cnt++;
        count = 2'd0; cur = 0; adv = 0; pend = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(n);
        t_cnt++; if (n < 0) $display("FAIL rst_mid_idle got=timeout exp=idle"); else p_cnt++;
        repeat (4) step();
        ready = 1'b1;
    endtask

    task automatic test_clear_mid();
        move(2, 6); move(1, 6); move(2, 6);
        ready = 1'b0;
        move(0, 6); move(1, 6);
        t_cnt++; if (total_a !== 16'd7 || delta_a !== 16'd2)
            $display("FAIL clr_pre got=%0d/%0d exp=7/2", total_a, delta_a); else p_cnt++;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        t_cnt++; if (clr_a !== 1'b1 || busy_a !== 1'b1)
            $display("FAIL clr_enter got=%b/%b exp=1/1", clr_a, busy_a); else p_cnt++;
        repeat (4) step();
        // Now in SETTLE waiting for zero; a re-request here must not restart CLEAR.
        count = 2'd0;
        repeat (2) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        t_cnt++; if (busy_a !== 1'b1) $display("FAIL clr_settle got=%b exp=1", busy_a); else p_cnt++;
        step();
        cur = 0; adv = 0; pend = 0;
        t_cnt++; if (busy_a !== 1'b0 || clr_a !== 1'b0) $display("FAIL clr_exit got=%b/%b exp=0/0", busy_a, clr_a); else p_cnt++;
        t_cnt++; if (total_a !== 16'd0 || dv_a !== 1'b0 || delta_a !== 16'd0)
            $display("FAIL clr_zero got=%0d/%b/%0d exp=0/0/0", total_a, dv_a, delta_a); else p_cnt++;
        repeat (3) step();
        ready = 1'b1;
    endtask

    task automatic test_overflow();
        int n;
        for (int k = 0; k < 9; k++) move((cur + 1) % N, 6);
        t_cnt++; if (total_b !== 3'd1 || ovf_b !== 1'b1)
            $display("FAIL ovf_b got=%0d/%b exp=1/1", total_b, ovf_b); else p_cnt++;
        t_cnt++; if (total_a !== 16'd9 || ovf_a !== 1'b0)
            $display("FAIL ovf_a got=%0d/%b exp=9/0", total_a, ovf_a); else p_cnt++;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        t_cnt++; if (ovf_b !== 1'b1 || busy_b !== 1'b1)
            $display("FAIL ovf_sticky got=%b/%b exp=1/1", ovf_b, busy_b); else p_cnt++;
        wait_idle(n);
        cur = 0; adv = 0; pend = 0;
        t_cnt++; if (n < 0 || ovf_b !== 1'b0 || total_b !== 3'd0)
            $display("FAIL ovf_cleared got=%b/%0d exp=0/0 (n=%0d)", ovf_b, total_b, n); else p_cnt++;
        repeat (3) step();
    endtask

    task automatic test_random();
        int exp_b;
        for (int it = 0; it < 30; it++) begin
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                count = 2'($urandom_range(0, 3));
                step();
            end
            move((cur + int'($urandom_range(1, N - 1))) % N, int'($urandom_range(5, 8)));
            t_cnt++; if (total_a !== 16'(adv % 65536) || total_b !== 3'(adv % 8) || ovf_b !== (adv >= 8))
                $display("FAIL rnd%0d_total got=%0d/%0d/%b exp=%0d/%0d/%b", it, total_a, total_b, ovf_b,
                         adv % 65536, adv % 8, adv >= 8); else p_cnt++;
            exp_b = (pend > 7) ? 7 : pend;
            t_cnt++; if (dv_a !== (pend != 0) || delta_a !== 16'(pend) || delta_b !== 3'(exp_b))
                $display("FAIL rnd%0d_delta got=%b/%0d/%0d exp=%b/%0d/%0d", it, dv_a, delta_a, delta_b,
                         pend != 0, pend, exp_b); else p_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        count = 2'd0;
        clear_req = 1'b0;
        ready = 1'b1;
        test_reset();
        test_boot();
        test_single_step();
        test_wrap();
        test_glitch();
        test_backpressure();
        test_reset_mid();
        test_clear_mid();
        test_overflow();
        test_random();
        $display("%0d/%0d checks passed", p_cnt, t_cnt);
        $finish;
    end
endmodule

// File: doc/mod_count_sampler.md
Name: mod_count_sampler

Overview:
- Downstream consumer of the asynchronous ripple mod-N counter (`clear_i`/`incr_i`/`count_o`).
- Safely samples that counter's output into the system clock domain and rejects ripple glitches with a stability filter.
- Converts modular count changes into increment deltas, accumulates them into a wide total, and offers each delta on a valid/ready interface.
- Owns the upstream counter's clear: clears it out of reset and on request.

Parameters:
- N, 3, modulus of the upstream counter (N ≥ 2).
- STABLE_CYCLES, 2, consecutive identical synchronized samples needed to accept a value (≥ 1).
- CLEAR_CYCLES, 2, minimum cycles `clear_o` is held asserted.
- ACC_W, 16, width of the total and delta outputs.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- count_i  in  $clog2(N)  upstream counter value (asynchronous to clk_i)
- clear_o  out  1  drives the upstream counter's clear_i
- clear_req_i  in  1  one-cycle request to restart counting from zero
- busy_o  out  1  high while a clear sequence is in progress
- total_o  out  ACC_W  accumulated increments since the last clear, mod 2^ACC_W
- overflow_o  out  1  sticky; total_o has wrapped
- delta_valid_o  out  1  delta_o holds a pending increment count
- delta_o  out  ACC_W  pending increments
- delta_ready_i  in  1  consumer accepts delta_o

Behaviour:
- Reset (`rst_ni` low, asynchronous), register values:
  - state = CLEAR, `clear_o` = 1, `busy_o` = 1
  - `total_o` = 0, `overflow_o` = 0
  - `delta_valid_o` = 0, `delta_o` = 0
  - synchronizer, filter, baseline and cycle counter = 0
- Synchronizer: two flops on `count_i`; the second-stage output is s.
- Stability filter:
  - A value v is accepted when s has equalled v on STABLE_CYCLES consecutive edges.
  - Any mismatch restarts the run.
  - A transient shorter than STABLE_CYCLES cycles is never accepted.
- Latency: after `count_i` first settles before edge 1, the resulting outputs update at edge STABLE_CYCLES+2 (edge 4 with defaults).
- Delta computation (state IDLE only):
  - d = (accepted − baseline) mod N, computed without signed arithmetic; the `count_i` wrap N−1→0 yields d = 1.
  - If d ≠ 0: `total_o` += d, mod 2^ACC_W. A carry out sets `overflow_o`. Baseline ← accepted.
  - Pending: `delta_o` += d, saturating at 2^ACC_W−1. `delta_valid_o` = 1.
- Handshake:
  - `delta_o` and `delta_valid_o` are stable while `delta_valid_o` && !`delta_ready_i`.
  - Deltas arriving during backpressure merge into `delta_o`.
  - On transfer (valid && ready): if no new d arrives in the same cycle, `delta_valid_o` → 0 and `delta_o` → 0. Otherwise `delta_o` ← d and `delta_valid_o` stays 1.
- Usage constraint: the upstream counter must advance fewer than N times per STABLE_CYCLES+2 clocks. More advances alias; no detection is required.
- FSM:
  - CLEAR: `clear_o` = 1, cycle counter increments. After CLEAR_CYCLES cycles → SETTLE.
  - SETTLE: `clear_o` = 1. When accepted value == 0 → IDLE. On exit: baseline = 0, `total_o` = 0, `overflow_o` = 0, `delta_valid_o` = 0, `delta_o` = 0, filter cleared.
  - IDLE: `clear_o` = 0, `busy_o` = 0. `clear_req_i` → CLEAR, counter = 0.
  - `busy_o` = (state ≠ IDLE).
  - `clear_req_i` is ignored outside IDLE.
  - No delta processing outside IDLE; `delta_ready_i` is ignored outside IDLE.
- Simultaneous `clear_req_i` and nonzero d in IDLE: the clear wins. The delta is discarded and all outputs are zeroed on SETTLE exit.
- `rst_ni` asserted mid-sequence or mid-handshake: immediate return to the reset values above.

Test Plan:
- Boot: release reset, hold `count_i` = 0 → `clear_o` = 1 for ≥ 2 cycles, IDLE reached, `busy_o` = 0, `total_o` = 0, `delta_valid_o` = 0.
- Single step: `count_i` 0→1 with `delta_ready_i` = 1 → at edge 4, `delta_valid_o` = 1, `delta_o` = 1, `total_o` = 1; next cycle `delta_valid_o` = 0.
- Wrap and multi-step: sequence 1→2→0 each held 6 cycles, then a 0→2 jump → `total_o` = 2, 3, then 5; the jump yields delta 2.
- Glitch and backpressure:
  - one-cycle `count_i` spike 0→3→0 → no delta, `total_o` unchanged;
  - with `delta_ready_i` = 0 over three +1 steps → `delta_o` = 3, held stable until ready, then `delta_valid_o` = 0.
- Clear mid-operation: pending `delta_o` = 2 and `total_o` = 7, pulse `clear_req_i` → `clear_o` asserted, `busy_o` = 1, `clear_req_i` re-pulsed during SETTLE ignored; on exit `total_o` = 0, `delta_valid_o` = 0.
- Overflow (ACC_W = 3): accumulate 9 increments → `total_o` = 1, `overflow_o` = 1, remaining set until the next clear completes.
